// File: rtl/clock_divider_multi_if.sv
// Divisor-load handshake bundle for clock_divider_multi.
// The master requests a load; the slave answers with load_ready.
interface clock_divider_multi_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 28,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic             load_valid;
    logic             load_ready;
    logic [CH_W-1:0]  load_ch;
    logic [DIV_W-1:0] load_div;

    modport master (
        output load_valid,
        output load_ch,
        output load_div,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_ch,
        input  load_div,
        output load_ready
    );
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel divider / tick generator used as clock enables.
// Divisor changes take effect only at period boundaries.
module clock_divider_multi #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 28,
    parameter int DEFAULT_DIV = 2,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] pulse_mode,
    input  logic              sync,
    clock_divider_multi_if.slave ld,
    output logic [NUM_CH-1:0] clock_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] upd_done
);

    localparam logic [DIV_W-1:0] DIV_DEF = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    logic [NUM_CH-1:0] pend_v;
    logic              load_ready;

    // Ready only for an in-range channel with no divisor waiting
    always_comb begin
        load_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ld.load_ch == CH_W'(i)) begin
                load_ready = ~pend_v[i];
            end
        end
    end

    assign ld.load_ready = load_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] div_act_q;
        logic [DIV_W-1:0] div_pend_q;
        logic             pend_q;
        logic             out_q;
        logic             tick_q;
        logic             upd_q;

        logic [DIV_W-1:0] d;
        logic [DIV_W-1:0] cnt_nxt;
        logic [DIV_W:0]   h;
        logic             wrap;
        logic             apply;
        logic             accept;

        // Effective divisor, period boundary and load/apply decisions
        always_comb begin
            d       = (div_act_q == '0) ? DIV_ONE : div_act_q;
            wrap    = (cnt_q == d - DIV_ONE);
            cnt_nxt = wrap ? '0 : cnt_q + DIV_ONE;
            h       = ({1'b0, d} + 1'b1) >> 1;
            apply   = pend_q & (~enable[g] | sync | wrap);
            accept  = ld.load_valid & load_ready
                    & (ld.load_ch == CH_W'(g));
        end

        // Counter, outputs and divisor hand-over for this channel
        always_ff @(posedge clock_in or posedge reset) begin
            if (reset) begin
                cnt_q      <= '0;
                div_act_q  <= DIV_DEF;
                div_pend_q <= DIV_DEF;
                pend_q     <= 1'b0;
                out_q      <= 1'b0;
                tick_q     <= 1'b0;
                upd_q      <= 1'b0;
            end else begin
                if (!enable[g]) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b0;
                    out_q  <= 1'b0;
                end else if (sync) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b1;
                    out_q  <= 1'b1;
                end else begin
                    cnt_q  <= cnt_nxt;
                    tick_q <= wrap;
                    out_q  <= pulse_mode[g] ? wrap
                                            : ({1'b0, cnt_nxt} < h);
                end

                upd_q <= apply;

                // apply needs pend_q=1, accept needs pend_q=0
                if (apply) begin
                    div_act_q <= div_pend_q;
                    pend_q    <= 1'b0;
                end else if (accept) begin
                    div_pend_q <= (ld.load_div == '0) ? DIV_ONE
                                                      : ld.load_div;
                    pend_q     <= 1'b1;
                end
            end
        end

        assign clock_out[g] = out_q;
        assign tick[g]      = tick_q;
        assign upd_done[g]  = upd_q;
        assign pend_v[g]    = pend_q;
    end

endmodule
